// File: rtl/magic_seq_gen_if.sv
// Control/data bundle of the magic-sequence transmitter: request side from master, byte stream back.
interface magic_seq_gen_if;
    logic       start;
    logic [3:0] count;
    logic       corrupt_en;
    logic [1:0] corrupt_pos;
    logic       hold;
    logic [7:0] out;
    logic       valid;
    logic       busy;
    logic       done;

    modport master (
        output start, count, corrupt_en, corrupt_pos, hold,
        input  out, valid, busy, done
    );

    modport slave (
        input  start, count, corrupt_en, corrupt_pos, hold,
        output out, valid, busy, done
    );
endinterface

// File: rtl/magic_seq_gen.sv
// Transmits the wake sequence 0x26,0xF5,0x6E with optional gaps, repetitions and byte corruption.
module magic_seq_gen #(
    parameter int unsigned GAP_CYCLES = 0,
    parameter logic [7:0]  FILL_BYTE  = 8'h00
) (
    input  logic           clk,
    input  logic           rst,
    magic_seq_gen_if.slave bus
);

    localparam int unsigned GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_FIN
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    rep_q, rep_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          cen_q, cen_d;
    logic [1:0]    cpos_q, cpos_d;
    logic [7:0]    out_q, out_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          advance;
    logic          load_byte;

    function automatic logic [7:0] seq_byte(input logic [1:0] i);
        case (i)
            2'd0:    seq_byte = 8'h26;
            2'd1:    seq_byte = 8'hF5;
            default: seq_byte = 8'h6E;
        endcase
    endfunction

    // Outputs are computed for the state being entered so they appear registered on the same edge.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rep_d     = rep_q;
        gap_d     = gap_q;
        cen_d     = cen_q;
        cpos_d    = cpos_q;
        out_d     = out_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        done_d    = done_q;
        advance   = 1'b0;
        load_byte = 1'b0;

        case (state_q)
            S_IDLE: begin
                out_d   = FILL_BYTE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                if (bus.start) begin
                    if (bus.count != 4'd0) begin
                        state_d   = S_SEND;
                        idx_d     = 2'd0;
                        rep_d     = bus.count;
                        cen_d     = bus.corrupt_en;
                        cpos_d    = bus.corrupt_pos;
                        load_byte = 1'b1;
                    end else begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                    end
                end
            end
            S_SEND: begin
                if (!bus.hold) begin
                    if (GAP_CYCLES > 0) begin
                        state_d = S_GAP;
                        gap_d   = GW'(GAP_CYCLES - 1);
                        out_d   = FILL_BYTE;
                        valid_d = 1'b0;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (!bus.hold) begin
                    if (gap_q == '0) begin
                        advance = 1'b1;
                    end else begin
                        gap_d = gap_q - 1'b1;
                    end
                end
            end
            S_FIN: begin
                if (!bus.hold) begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            if (idx_q != 2'd2) begin
                idx_d     = idx_q + 2'd1;
                state_d   = S_SEND;
                load_byte = 1'b1;
            end else begin
                rep_d = rep_q - 4'd1;
                if (rep_q != 4'd1) begin
                    idx_d     = 2'd0;
                    state_d   = S_SEND;
                    load_byte = 1'b1;
                end else begin
                    state_d = S_FIN;
                    out_d   = FILL_BYTE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
        end

        if (load_byte) begin
            out_d   = seq_byte(idx_d) ^ ((cen_d && (cpos_d == idx_d)) ? 8'hFF : 8'h00);
            valid_d = 1'b1;
            busy_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
            cen_q   <= 1'b0;
            cpos_q  <= '0;
            out_q   <= FILL_BYTE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            cen_q   <= cen_d;
            cpos_q  <= cpos_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.out   = out_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule
